// File: rtl/l0_seq_pkg.sv
// l0_seq_pkg: state encoding and default sizing shared by the L0 FIFO sequencer files
package l0_seq_pkg;
    localparam int STATE_W = 3;
    localparam int ROW_DEF = 8;
    localparam int DEPTH_DEF = 64;
    localparam int LEN_BW_DEF = 7;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/l0_seq_ctrl_if.sv
// l0_seq_ctrl_if: job, upstream and FIFO-bank signals of the sequencer; stall_cnt exists only with L0_SEQ_PERF_EN
interface l0_seq_ctrl_if
    import l0_seq_pkg::*;
#(
    parameter int row = ROW_DEF,
    parameter int len_bw = LEN_BW_DEF
);
    logic start;
    logic [len_bw-1:0] len;
    logic in_valid;
    logic in_ready;
    logic [row-1:0] fifo_full;
    logic [row-1:0] fifo_empty;
    logic out_ready;
    logic fifo_wr;
    logic [row-1:0] fifo_rd;
    logic busy;
    logic done;
    logic underflow;
`ifdef L0_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif
    modport master (
        input start, len, in_valid, fifo_full, fifo_empty, out_ready,
`ifdef L0_SEQ_PERF_EN
        output stall_cnt,
`endif
        output in_ready, fifo_wr, fifo_rd, busy, done, underflow
    );
    modport slave (
        output start, len, in_valid, fifo_full, fifo_empty, out_ready,
`ifdef L0_SEQ_PERF_EN
        input stall_cnt,
`endif
        input in_ready, fifo_wr, fifo_rd, busy, done, underflow
    );
endinterface

// File: rtl/l0_rd_skew_chain.sv
// l0_rd_skew_chain: row-1 stage enable-gated shift register turning issue/adv into diagonally skewed read strobes
module l0_rd_skew_chain
    import l0_seq_pkg::*;
#(
    parameter int row = ROW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           issue,
    output logic [row-1:0] rd,
    output logic           idle_next
);
    logic [row-2:0] sk_q, sk_d;
    logic [row-1:0] sh;
    always_comb begin
        sh = {sk_q, issue};
        sk_d = en ? sh[row-2:0] : sk_q;
        rd = en ? sh : '0;
        idle_next = ~|sk_d;
    end
    always_ff @(posedge clk) begin
        if (reset) sk_q <= '0;
        else sk_q <= sk_d;
    end
endmodule

// File: rtl/l0_seq_ctrl.sv
// l0_seq_ctrl: load/drain sequencer for the L0 row FIFO bank; L0_SEQ_PERF_EN adds the stall_cnt counter
module l0_seq_ctrl
    import l0_seq_pkg::*;
#(
    parameter int row = ROW_DEF,
    parameter int depth = DEPTH_DEF,
    parameter int len_bw = LEN_BW_DEF
) (
    input logic           clk,
    input logic           reset,
    l0_seq_ctrl_if.master bus
);
    localparam logic [len_bw-1:0] depth_c = len_bw'(depth);
    state_e state_q, state_d;
    logic [len_bw-1:0] l_q, l_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, len_c;
    logic underflow_q, underflow_d;
    logic in_ready, accept, issue, skew_en, skew_idle;
    logic [row-1:0] rd;
    always_comb begin
        len_c = bus.len > depth_c ? depth_c : bus.len;
        in_ready = state_q == S_LOAD && ~|bus.fifo_full;
        accept = in_ready & bus.in_valid;
        issue = state_q == S_DRAIN && rd_cnt_q < l_q;
        skew_en = bus.out_ready && (state_q == S_DRAIN || state_q == S_FLUSH);
        state_d = state_q;
        l_d = l_q;
        wr_cnt_d = wr_cnt_q + len_bw'(accept);
        rd_cnt_d = rd_cnt_q + len_bw'(issue & skew_en);
        underflow_d = underflow_q | (|(rd & bus.fifo_empty));
        case (state_q)
            S_IDLE: if (bus.start) begin
                l_d = len_c;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                state_d = len_c == '0 ? S_DONE : S_LOAD;
            end
            S_LOAD:  state_d = wr_cnt_d == l_q ? S_DRAIN : S_LOAD;
            S_DRAIN: state_d = rd_cnt_d == l_q ? S_FLUSH : S_DRAIN;
            S_FLUSH: state_d = skew_idle ? S_DONE : S_FLUSH;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            l_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q <= l_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            underflow_q <= underflow_d;
        end
    end
    l0_rd_skew_chain #(.row(row)) u_skew (
        .clk(clk),
        .reset(reset),
        .en(skew_en),
        .issue(issue),
        .rd(rd),
        .idle_next(skew_idle)
    );
    assign bus.in_ready = in_ready;
    assign bus.fifo_wr = accept;
    assign bus.fifo_rd = rd;
    assign bus.busy = state_q != S_IDLE;
    assign bus.done = state_q == S_DONE;
    assign bus.underflow = underflow_q;
`ifdef L0_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic stall;
    always_comb begin
        stall = ((state_q == S_DRAIN || state_q == S_FLUSH) && !bus.out_ready) ||
                (state_q == S_LOAD && bus.in_valid && !in_ready);
        stall_cnt_d = (state_q == S_IDLE && bus.start) ? 16'd0 :
                      (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_l0_seq_ctrl.sv
// tb_l0_seq_ctrl: directed jobs against l0_seq_ctrl with hand-computed cycle and count expectations
module tb_l0_seq_ctrl;
    localparam int ROW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vec_cnt = 0;
    int err_cnt = 0;
    int wr_n, done_n, done_cyc, first0_cyc, busy_after, rd_in_stall, bad_full, uf_pre, post_rst, uf_end;
    int rd_n [ROW];
    int first_a [ROW];
    int last_a [ROW];
    l0_seq_ctrl_if bus ();
    l0_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic run_job(input int l, input int ncyc, input int stall_a, input int stall_n,
                           input int full_a, input int full_n, input int empty_at, input int rst_at);
        bit started = 0;
        int aidx = 0;
        wr_n = 0; done_n = 0; done_cyc = -1; first0_cyc = -1; busy_after = -1;
        rd_in_stall = 0; bad_full = 0; uf_pre = -1; post_rst = -1; uf_end = -1;
        for (int i = 0; i < ROW; i++) begin
            rd_n[i] = 0; first_a[i] = -1; last_a[i] = -1;
        end
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0);
            bus.len = 7'(l);
            bus.out_ready = !(k >= stall_a && k < stall_a + stall_n);
            bus.fifo_full = (k >= full_a && k < full_a + full_n) ? 8'h08 : 8'h00;
            bus.fifo_empty = (k == empty_at) ? 8'h04 : 8'h00;
            reset = (k == rst_at);
            #1;
            if (bus.fifo_wr) wr_n++;
            if (!bus.out_ready && bus.fifo_rd != 0) rd_in_stall++;
            if (bus.fifo_full != 0 && (bus.fifo_wr || bus.in_ready)) bad_full++;
            if (bus.fifo_rd[0] && !started) begin
                started = 1; aidx = 0; first0_cyc = k;
            end
            for (int i = 0; i < ROW; i++) if (bus.fifo_rd[i]) begin
                if (rd_n[i] == 0) first_a[i] = aidx;
                last_a[i] = aidx;
                rd_n[i]++;
            end
            if (bus.done) begin done_n++; done_cyc = k; end
            if (done_n > 0 && k == done_cyc + 1) busy_after = int'(bus.busy);
            if (k == rst_at) uf_pre = int'(bus.underflow);
            if (k == rst_at + 1) post_rst = int'({bus.busy, bus.done, |bus.fifo_rd, bus.underflow, bus.in_ready});
            if (k == ncyc - 1) uf_end = int'(bus.underflow);
            if (started && bus.out_ready) aidx++;
        end
    endtask
    initial begin
        bus.start = 0; bus.len = '0; bus.in_valid = 1; bus.out_ready = 1;
        bus.fifo_full = '0; bus.fifo_empty = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_fifo_wr", int'(bus.fifo_wr), 0);
        chk("rst_fifo_rd", int'(bus.fifo_rd), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_underflow", int'(bus.underflow), 0);
        reset = 0;
        run_job(4, 20, -1, 0, -1, 0, -1, -1);
        chk("t1_wr", wr_n, 4);
        chk("t1_rd0_n", rd_n[0], 4);
        chk("t1_rd7_n", rd_n[7], 4);
        chk("t1_first0_cyc", first0_cyc, 5);
        chk("t1_rd7_first", first_a[7], 7);
        chk("t1_rd7_last", last_a[7], 10);
        chk("t1_done_n", done_n, 1);
        chk("t1_done_cyc", done_cyc, 16);
        chk("t1_busy_after", busy_after, 0);
        chk("t1_underflow", uf_end, 0);
        run_job(0, 6, -1, 0, -1, 0, -1, -1);
        chk("t2_wr", wr_n, 0);
        chk("t2_rd0", rd_n[0] + rd_n[7], 0);
        chk("t2_done_cyc", done_cyc, 1);
        chk("t2_done_n", done_n, 1);
        chk("t2_busy_after", busy_after, 0);
        run_job(100, 140, -1, 0, -1, 0, -1, -1);
        chk("t3_wr", wr_n, 64);
        chk("t3_rd0_n", rd_n[0], 64);
        chk("t3_rd7_n", rd_n[7], 64);
        chk("t3_rd7_last", last_a[7], 70);
        chk("t3_done_cyc", done_cyc, 136);
        run_job(8, 30, -1, 0, 2, 5, -1, -1);
        chk("t4_full_block", bad_full, 0);
        chk("t4_wr", wr_n, 8);
        chk("t4_first0_cyc", first0_cyc, 14);
        chk("t4_rd3_n", rd_n[3], 8);
        chk("t4_done_n", done_n, 1);
        run_job(4, 24, 6, 2, -1, 0, -1, -1);
        chk("t5_rd_in_stall", rd_in_stall, 0);
        for (int i = 0; i < ROW; i++) chk($sformatf("t5_rd%0d_n", i), rd_n[i], 4);
        chk("t5_rd7_first", first_a[7], 7);
        chk("t5_rd7_last", last_a[7], 10);
        chk("t5_rd4_first", first_a[4], 4);
        chk("t5_done_cyc", done_cyc, 18);
        run_job(4, 20, -1, 0, -1, 0, 7, 12);
        chk("t6_rd2_n", rd_n[2], 4);
        chk("t6_underflow_pre", uf_pre, 1);
        chk("t6_post_rst", post_rst, 0);
        chk("t6_done_n", done_n, 0);
        chk("t6_underflow_end", uf_end, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/l0_seq_ctrl.md
Name: l0_seq_ctrl

Overview:
Sequencer for a bank of `row` depth-64 input FIFOs that feed the systolic array.
- Accepts one load/drain job: fill all row FIFOs with `len` vectors in lock-step, then drain them.
- Drain uses a diagonal skew: row i reads lag row 0 by i advance cycles, producing the staggered wavefront the PE array expects.
- Sits between the core instruction decoder and the FIFO bank; owns every FIFO wr/rd strobe.

Parameters:
row, 8, number of FIFOs in the bank (>=2)
depth, 64, FIFO depth; job length is clamped to this
len_bw, 7, width of len and of the internal counters

Ports:
clk  input  1  core clock, all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  job request pulse; sampled only in IDLE
len  input  len_bw  vectors per job; 0 = empty job; values >depth clamped to depth
in_valid  input  1  upstream vector valid for the bank
in_ready  output  1  bank can accept (no FIFO full, state LOAD)
fifo_full  input  row  per-FIFO full flags
fifo_empty  input  row  per-FIFO empty flags
out_ready  input  1  array accepts the current wavefront step
fifo_wr  output  1  common write strobe to all FIFOs
fifo_rd  output  row  per-FIFO read strobes (skewed)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at job completion
underflow  output  1  sticky: a rd strobe hit an empty FIFO

Behaviour:
Interface:
- Single clock `clk`.
- `reset` is synchronous and active-high.
- On reset: state=IDLE; counters=0; skew register=0; underflow=0.
- Reset outputs: in_ready=0, fifo_wr=0, fifo_rd=0, busy=0, done=0.
- Reset mid-job aborts the job immediately; FIFO contents are not touched.

States: IDLE -> LOAD -> DRAIN -> FLUSH -> DONE -> IDLE; encoded as a 3-bit registered state.

IDLE:
- On start: latch L = min(len, depth) and clear wr_cnt/rd_cnt.
- If L=0, go to DONE; otherwise go to LOAD.
- start outside IDLE is ignored.

LOAD:
- in_ready = ~|fifo_full (combinational).
- fifo_wr = in_valid & in_ready.
- Each accept increments wr_cnt. The accept that makes wr_cnt==L moves to DRAIN next cycle.

DRAIN:
- issue = (rd_cnt < L). adv = out_ready.
- fifo_rd[0] = issue & adv; fifo_rd[i] = sk[i-1] & adv for i>=1.
- sk is a row-1 bit shift register; when adv=1: sk <= {sk[row-3:0], issue}, and rd_cnt increments if issue.
- When adv=0, sk and rd_cnt hold and all fifo_rd=0 (whole wavefront stalls).
- When rd_cnt reaches L, go to FLUSH.

FLUSH: issue=0; sk keeps shifting on adv; when sk==0, go to DONE. Last row's final read occurs row-1 advances after row 0's last.

DONE: done=1 for exactly one cycle, then IDLE.

Latency and counts:
- Row i sees exactly L reads; its first read is i advances after row 0's first.
- Minimum drain time with out_ready=1 is L+row-1 cycles.

underflow:
- Sets when any (fifo_rd[i] & fifo_empty[i]) is true.
- Clears only on reset.
- The controller does not block on empty; the upstream protocol guarantees fill.

Arithmetic: counters are len_bw bits, with no wrap inside a job, since L<=depth<2^len_bw.

Optional Feature:
Macro L0_SEQ_PERF_EN.
- Defined: adds output stall_cnt [15:0].
  - Counts cycles in DRAIN/FLUSH with out_ready=0, plus LOAD cycles with in_valid=1 & in_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on start acceptance.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package l0_seq_pkg holds:
  - state localparams S_IDLE=0, S_LOAD=1, S_DRAIN=2, S_FLUSH=3, S_DONE=4, plus the state width;
  - default row/depth/len_bw constants.
- One sub-module, l0_rd_skew_chain: a row-1 stage enable-gated shift register producing fifo_rd from issue/adv.

Test Plan:
1. row=8, len=4, in_valid=1 and out_ready=1 throughout -> 4 fifo_wr pulses; fifo_rd[0] high cycles 0-3 of DRAIN, fifo_rd[7] high cycles 7-10; done pulses once; busy low the cycle after done.
2. len=0 -> IDLE->DONE->IDLE; no fifo_wr/fifo_rd; done one cycle after start.
3. len=100 -> clamped: exactly 64 fifo_wr pulses and 64 reads per row.
4. LOAD with fifo_full[3]=1 for 5 cycles -> in_ready=0 and fifo_wr=0 for those 5 cycles; wr_cnt holds; job completes normally afterwards.
5. DRAIN with out_ready toggling 1,0,0,1 -> fifo_rd all 0 in the stalled cycles; skew preserved (row i reads still exactly i advances behind); per-row read count = L.
6. reset asserted mid-FLUSH -> next cycle state=IDLE, fifo_rd=0, busy=0, no done pulse; forced fifo_empty[2]=1 during a rd[2] before the reset -> underflow=1 until reset.
